// File: rtl/aemb_fsl_hub_pkg.sv
// Shared definitions for the AEMB FSL hub: tag bit positions, FSM states
// and the width of the core-side channel index.
package aemb_fsl_hub_pkg;

    localparam int TAG_CTL = 1;   // control access (cput/cget)
    localparam int TAG_NBL = 0;   // non-blocking access (nput/nget)
    localparam int ADR_W   = 5;   // channel index width, up to 32 channels

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } fsl_state_t;

endpackage

// File: rtl/aemb_fsl_fifo.sv
// Small synchronous FIFO with registered storage and a visible head entry.
// Full/empty come from the count at the start of the cycle, so a pop in
// the same cycle never frees room for a push into a full FIFO.
module aemb_fsl_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_dat,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_head  = r_mem[r_rp];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Storage, pointers (wrap naturally, DEPTH is a power of 2) and count
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= i_dat;
                r_wp        <= r_wp + AW'(1);
            end
            if (w_pop)
                r_rp <= r_rp + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/aemb_fsl_hub.sv
// Multi-channel FSL hub: one stb/ack core port addressed by channel number,
// each channel backed by an outbound (PUT) and an inbound (GET) FIFO that
// carry a control bit alongside the data.
module aemb_fsl_hub
    import aemb_fsl_hub_pkg::*;
#(
    parameter int CH    = 4,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic             sys_clk_i,
    input  logic             sys_rst_i,
    input  logic             fsl_stb_i,
    input  logic             fsl_wre_i,
    input  logic [ADR_W-1:0] fsl_adr_i,
    input  logic [1:0]       fsl_tag_i,
    input  logic [DW-1:0]    fsl_dat_i,
    output logic [DW-1:0]    fsl_dat_o,
    output logic             fsl_ack_o,
    output logic             fsl_err_o,
    output logic [CH*DW-1:0] m_dat_o,
    output logic [CH-1:0]    m_ctl_o,
    output logic [CH-1:0]    m_vld_o,
    input  logic [CH-1:0]    m_rdy_i,
    input  logic [CH*DW-1:0] s_dat_i,
    input  logic [CH-1:0]    s_ctl_i,
    input  logic [CH-1:0]    s_vld_i,
    output logic [CH-1:0]    s_rdy_o
);

    fsl_state_t     r_state;
    logic           r_ack;
    logic           r_err;
    logic [DW-1:0]  r_dat;

    // Status padded to the full 32-entry index space so the 5-bit channel
    // index selects directly; unused channels read as full=0/empty=0.
    logic [31:0]        w_ofull;
    logic [31:0]        w_iempty;
    logic [31:0][DW:0]  w_ihead;
    logic [CH-1:0][DW:0] w_ohead;
    logic [CH-1:0]      w_oempty;
    logic [CH-1:0]      w_ifull;
    logic               w_adr_ok;
    logic               w_done, w_err, w_dat_upd, w_put, w_get;
    logic [DW-1:0]      w_dat;

    assign w_adr_ok = ({1'b0, fsl_adr_i} < (ADR_W+1)'(CH));

    genvar c;
    generate
        for (c = 0; c < 32; c++) begin : g_ch
            if (c < CH) begin : g_fifo
                aemb_fsl_fifo #(.W(DW+1), .DEPTH(DEPTH)) u_out (
                    .i_clk   (sys_clk_i),
                    .i_rst_n (sys_rst_i),
                    .i_push  (w_put & (fsl_adr_i == ADR_W'(c))),
                    .i_pop   (m_rdy_i[c]),
                    .i_dat   ({fsl_tag_i[TAG_CTL], fsl_dat_i}),
                    .o_head  (w_ohead[c]),
                    .o_full  (w_ofull[c]),
                    .o_empty (w_oempty[c])
                );
                aemb_fsl_fifo #(.W(DW+1), .DEPTH(DEPTH)) u_in (
                    .i_clk   (sys_clk_i),
                    .i_rst_n (sys_rst_i),
                    .i_push  (s_vld_i[c]),
                    .i_pop   (w_get & (fsl_adr_i == ADR_W'(c))),
                    .i_dat   ({s_ctl_i[c], s_dat_i[c*DW +: DW]}),
                    .o_head  (w_ihead[c]),
                    .o_full  (w_ifull[c]),
                    .o_empty (w_iempty[c])
                );
                assign m_dat_o[c*DW +: DW] = w_ohead[c][DW-1:0];
                assign m_ctl_o[c]          = w_ohead[c][DW];
                assign m_vld_o[c]          = ~w_oempty[c];
                assign s_rdy_o[c]          = ~w_ifull[c];
            end else begin : g_pad
                assign w_ofull[c]  = 1'b0;
                assign w_iempty[c] = 1'b0;
                assign w_ihead[c]  = '0;
            end
        end
    endgenerate

    // Evaluate the pending request against FIFO status sampled this cycle
    always_comb begin
        w_done    = 1'b0;
        w_err     = 1'b0;
        w_dat_upd = 1'b0;
        w_dat     = '0;
        w_put     = 1'b0;
        w_get     = 1'b0;
        if (r_state == ST_IDLE && fsl_stb_i) begin
            if (!w_adr_ok) begin
                w_done    = 1'b1;
                w_err     = 1'b1;
                w_dat_upd = 1'b1;
            end else if (fsl_wre_i) begin
                if (!w_ofull[fsl_adr_i]) begin
                    w_done = 1'b1;
                    w_put  = 1'b1;
                end else if (fsl_tag_i[TAG_NBL]) begin
                    w_done = 1'b1;
                    w_err  = 1'b1;
                end
            end else if (!w_iempty[fsl_adr_i]) begin
                w_done    = 1'b1;
                w_get     = 1'b1;
                w_dat_upd = 1'b1;
                w_dat     = w_ihead[fsl_adr_i][DW-1:0];
                w_err     = (w_ihead[fsl_adr_i][DW] != fsl_tag_i[TAG_CTL]);
            end else if (fsl_tag_i[TAG_NBL]) begin
                w_done    = 1'b1;
                w_err     = 1'b1;
                w_dat_upd = 1'b1;
            end
        end
    end

    // Request FSM with registered ack/err/data; ACK always lasts one cycle
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_done) begin
                        r_state <= ST_ACK;
                        r_ack   <= 1'b1;
                        r_err   <= w_err;
                        if (w_dat_upd) r_dat <= w_dat;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    assign fsl_ack_o = r_ack;
    assign fsl_err_o = r_err;
    assign fsl_dat_o = r_dat;

endmodule

// File: tb/tb_aemb_fsl_hub.sv
// Directed bench for aemb_fsl_hub (CH=4, DW=32, DEPTH=4).
module tb_aemb_fsl_hub;

    localparam int CH = 4;
    localparam int DW = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             stb = 1'b0, wre = 1'b0;
    logic [4:0]       adr = '0;
    logic [1:0]       tag = '0;
    logic [DW-1:0]    dat_i = '0;
    logic [DW-1:0]    dat_o;
    logic             ack, err;
    logic [CH*DW-1:0] m_dat;
    logic [CH-1:0]    m_ctl, m_vld, s_rdy;
    logic [CH-1:0]    m_rdy = '0;
    logic [CH*DW-1:0] s_dat = '0;
    logic [CH-1:0]    s_ctl = '0, s_vld = '0;

    int n_tot = 0;
    int n_bad = 0;

    aemb_fsl_hub #(.CH(CH), .DW(DW), .DEPTH(4)) dut (
        .sys_clk_i (clk),   .sys_rst_i (rst_n),
        .fsl_stb_i (stb),   .fsl_wre_i (wre),   .fsl_adr_i (adr),
        .fsl_tag_i (tag),   .fsl_dat_i (dat_i), .fsl_dat_o (dat_o),
        .fsl_ack_o (ack),   .fsl_err_o (err),
        .m_dat_o   (m_dat), .m_ctl_o   (m_ctl), .m_vld_o   (m_vld), .m_rdy_i (m_rdy),
        .s_dat_i   (s_dat), .s_ctl_i   (s_ctl), .s_vld_i   (s_vld), .s_rdy_o (s_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", t, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait up to max edges for ack; inputs stay as driven
    task automatic wait_ack(input int max, output bit got, output int cyc);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < max) begin
            tick();
            cyc++;
            if (ack) got = 1'b1;
        end
    endtask

    // Full request: drive, wait for ack, capture, release, return to idle
    task automatic req(input logic w, input logic [4:0] a, input logic [1:0] t,
                       input logic [DW-1:0] d, output bit got, output int cyc,
                       output logic [DW-1:0] rd, output logic re);
        stb = 1'b1; wre = w; adr = a; tag = t; dat_i = d;
        wait_ack(8, got, cyc);
        rd = dat_o;
        re = err;
        stb = 1'b0;
        tick();
    endtask

    // Write one entry into an inbound channel
    task automatic inb(input int ch, input logic [DW-1:0] d, input logic c);
        s_dat[ch*DW +: DW] = d;
        s_ctl[ch] = c;
        s_vld[ch] = 1'b1;
        tick();
        s_vld[ch] = 1'b0;
    endtask

    bit            got;
    int            cyc;
    logic [DW-1:0] rd;
    logic          re;
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_h;

    initial begin
        // reset state
        #2;
        chk("rst_ack", ack, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_vld", m_vld, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_rdy", s_rdy, 4'hF);

        // blocking GET on empty ch0, reset on cycle 3
        stb = 1'b1; wre = 1'b0; adr = 5'd0; tag = 2'b00;
        wait_ack(3, got, cyc);
        chk("midget_noack", got, 0);
        rst_n = 1'b0;
        #2;
        chk("midget_ack_in_rst", ack, 0);
        stb = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("midget_ack_after", ack, 0);
        chk("midget_vld", m_vld, 0);
        chk("midget_rdy", s_rdy, 4'hF);

        // PUT ch2
        req(1'b1, 5'd2, 2'b00, 32'hDEADBEEF, got, cyc, rd, re);
        chk("put2_ack", got, 1);
        chk("put2_lat", cyc, 1);
        chk("put2_err", re, 0);
        chk("put2_vld", m_vld[2], 1);
        chk("put2_dat", m_dat[2*DW +: DW], 32'hDEADBEEF);
        chk("put2_ctl", m_ctl[2], 0);
        m_rdy[2] = 1'b1;
        tick();
        m_rdy[2] = 1'b0;
        chk("put2_popped", m_vld[2], 0);

        // fill ch1, then blocking PUT waits for space
        for (int i = 0; i < 4; i++) begin
            req(1'b1, 5'd1, 2'b00, 32'h100 + i, got, cyc, rd, re);
            chk("fill_ack", got, 1);
        end
        stb = 1'b1; wre = 1'b1; adr = 5'd1; tag = 2'b00; dat_i = 32'h200;
        wait_ack(3, got, cyc);
        chk("full_block", got, 0);
        m_rdy[1] = 1'b1;
        tick();
        m_rdy[1] = 1'b0;
        wait_ack(4, got, cyc);
        chk("unblock_ack", got, 1);
        chk("unblock_lat", cyc, 1);
        chk("unblock_err", err, 0);
        stb = 1'b0;
        tick();
        chk("ch1_head", m_dat[1*DW +: DW], 32'h101);
        req(1'b1, 5'd1, 2'b01, 32'h300, got, cyc, rd, re);
        chk("nput_full_ack", got, 1);
        chk("nput_full_err", re, 1);
        // drain: exactly 4 entries in order
        m_rdy[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_h = (i == 3) ? 32'h200 : 32'h101 + i;
            chk("drain1_vld", m_vld[1], 1);
            chk("drain1_dat", m_dat[1*DW +: DW], exp_h);
            tick();
        end
        m_rdy[1] = 1'b0;
        chk("drain1_empty", m_vld[1], 0);

        // inbound ch3 with control bit
        inb(3, 32'h12345678, 1'b1);
        chk("in3_vld_rdy", s_rdy[3], 1);
        req(1'b0, 5'd3, 2'b00, '0, got, cyc, rd, re);
        chk("get3_dat", rd, 32'h12345678);
        chk("get3_err_mis", re, 1);
        inb(3, 32'h12345678, 1'b1);
        req(1'b0, 5'd3, 2'b10, '0, got, cyc, rd, re);
        chk("cget3_dat", rd, 32'h12345678);
        chk("cget3_err", re, 0);
        req(1'b0, 5'd3, 2'b01, '0, got, cyc, rd, re);
        chk("nget3_ack", got, 1);
        chk("nget3_err", re, 1);
        chk("nget3_dat", rd, 0);

        // out-of-range channel, blocking GET
        inb(0, 32'hCAFE0000, 1'b0);
        req(1'b0, 5'd31, 2'b00, '0, got, cyc, rd, re);
        chk("bad_adr_lat", cyc, 1);
        chk("bad_adr_err", re, 1);
        chk("bad_adr_dat", rd, 0);
        chk("bad_adr_vld", m_vld, 0);
        chk("bad_adr_ch0", dut.g_ch[0].g_fifo.u_in.o_empty, 0);
        req(1'b0, 5'd0, 2'b00, '0, got, cyc, rd, re);
        chk("ch0_kept", rd, 32'hCAFE0000);

        // wrap: outbound ch0 held at 2 entries with simultaneous push+pop
        for (int i = 0; i < 2; i++) begin
            req(1'b1, 5'd0, 2'b00, 32'h500 + i, got, cyc, rd, re);
            q.push_back(32'h500 + i);
        end
        for (int i = 2; i < 12; i++) begin
            stb = 1'b1; wre = 1'b1; adr = 5'd0; tag = 2'b00; dat_i = 32'h500 + i;
            m_rdy[0] = 1'b1;
            exp_h = q.pop_front();
            chk("wrap_head", m_dat[0 +: DW], exp_h);
            q.push_back(32'h500 + i);
            tick();
            m_rdy[0] = 1'b0;
            chk("wrap_ack", ack, 1);
            stb = 1'b0;
            tick();
        end
        m_rdy[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_h = q.pop_front();
            chk("wrap_vld", m_vld[0], 1);
            chk("wrap_tail", m_dat[0 +: DW], exp_h);
            tick();
        end
        m_rdy[0] = 1'b0;
        chk("wrap_empty", m_vld[0], 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
